// File: rtl/load_store_unit_if.sv
// Core request/response and data-bus signals of the load/store unit.
// "master" is the unit's own view; "slave" is the core/memory environment.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [2:0]            req_funct3_i;
  logic                  resp_valid_o;
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_err_o;
  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [7:0]            mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_funct3_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: splits each access into one or two 8-byte bus beats.
// Response 3 cycles after accept (5 if split, 1 if illegal); one access in flight, no response backpressure.
module load_store_unit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP, S_ERR
  } state_t;

  state_t                r_state;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [7:0]            r_be1;
  logic [DATA_WIDTH-1:0] r_wd1;
  logic [DATA_WIDTH-1:0] r_rd0;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_be;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic [15:0]           w_in_mask;
  logic [127:0]          w_in_wd;
  logic                  w_in_illegal;
  logic [DATA_WIDTH-1:0] w_addr1;

  function automatic logic [15:0] lane_mask(input logic [2:0] off, input logic [1:0] sz);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << sz)) - 16'd1;
    return m << off;
  endfunction

  // Shift the two-beat window down to the access offset, then extend by funct3.
  function automatic logic [63:0] load_extend(input logic [127:0] pair, input logic [2:0] off,
                                              input logic [2:0] f3);
    logic [127:0] sh;
    logic [63:0]  r;
    logic [63:0]  res;
    sh  = pair >> {off, 3'b000};
    r   = sh[63:0];
    res = 64'd0;
    case (f3)
      3'b000:  res = {{56{r[7]}}, r[7:0]};
      3'b001:  res = {{48{r[15]}}, r[15:0]};
      3'b010:  res = {{32{r[31]}}, r[31:0]};
      3'b011:  res = r;
      3'b100:  res = {56'd0, r[7:0]};
      3'b101:  res = {48'd0, r[15:0]};
      3'b110:  res = {32'd0, r[31:0]};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  assign w_in_mask    = lane_mask(bus.req_addr_i[2:0], bus.req_funct3_i[1:0]);
  assign w_in_wd      = {64'd0, bus.req_wdata_i} << {bus.req_addr_i[2:0], 3'b000};
  assign w_in_illegal = bus.req_we_i ? bus.req_funct3_i[2] : (bus.req_funct3_i == 3'b111);
  assign w_addr1      = {r_addr[DATA_WIDTH-1:3], 3'b000} + 64'd8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_funct3     <= 3'b000;
      r_be1        <= 8'd0;
      r_wd1        <= '0;
      r_rd0        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= 8'd0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_req_ready <= 1'b0;
            r_we        <= bus.req_we_i;
            r_addr      <= bus.req_addr_i;
            r_funct3    <= bus.req_funct3_i;
            r_be1       <= w_in_mask[15:8];
            r_wd1       <= w_in_wd[127:64];
            r_rd0       <= '0;
            if (w_in_illegal) begin
              r_state      <= S_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state     <= S_REQ0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.req_we_i;
              r_mem_addr  <= {bus.req_addr_i[DATA_WIDTH-1:3], 3'b000};
              r_mem_be    <= w_in_mask[7:0];
              r_mem_wdata <= w_in_wd[63:0];
            end
          end
        end
        S_REQ0: begin
          if (bus.mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT0;
          end
        end
        S_WAIT0: begin
          if (bus.mem_rvalid_i) begin
            if (r_be1 != 8'd0) begin
              r_rd0       <= bus.mem_rdata_i;
              r_state     <= S_REQ1;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= w_addr1;
              r_mem_be    <= r_be1;
              r_mem_wdata <= r_wd1;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= r_we ? '0 : load_extend({64'd0, bus.mem_rdata_i}, r_addr[2:0], r_funct3);
            end
          end
        end
        S_REQ1: begin
          if (bus.mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (bus.mem_rvalid_i) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? '0 : load_extend({bus.mem_rdata_i, r_rd0}, r_addr[2:0], r_funct3);
          end
        end
        S_RESP, S_ERR: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_rdata <= '0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = r_req_ready;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_err_o   = r_resp_err;
  assign bus.resp_rdata_o = r_resp_rdata;
  assign bus.mem_req_o    = r_mem_req;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_be_o     = r_mem_be;
  assign bus.mem_wdata_o  = r_mem_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the data memory bus. Sits in the MEM stage.
- Accepts one load/store per handshake, encoded with RISC-V funct3.
- Turns each access into one or two 8-byte-aligned bus transactions with byte enables. An access that crosses an 8-byte boundary becomes two transactions.
- Returns sign- or zero-extended load data, plus a completion/error pulse.

Parameters:
- DATA_WIDTH, 64, width of data and address; must be 64 (8-byte bus granule).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  unit can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  64  byte address.
- req_wdata_i  input  64  store data, LSB-aligned.
- req_funct3_i  input  3  load: LB/LH/LW/LD/LBU/LHU/LWU; store: SB/SH/SW/SD.
- resp_valid_o  output  1  one-cycle completion pulse.
- resp_rdata_o  output  64  extended load data; 0 for stores.
- resp_err_o  output  1  illegal funct3; qualified by resp_valid_o.
- mem_req_o  output  1  bus request.
- mem_gnt_i  input  1  bus grant.
- mem_we_o  output  1  bus write.
- mem_addr_o  output  64  aligned address, bits [2:0] always 0.
- mem_be_o  output  8  byte enables; bit i = byte i.
- mem_wdata_o  output  64  lane-positioned write data.
- mem_rvalid_i  input  1  bus completion (loads and stores).
- mem_rdata_i  input  64  bus read data.

Behaviour:
Reset
- rst asserted forces state IDLE immediately.
- Outputs during reset: mem_req_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
- req_ready_o=1 in the first cycle after rst deasserts.

Request acceptance
- req_ready_o=1 only in IDLE.
- On req_valid_i & req_ready_o, register we, addr, wdata and funct3.
- size = 1 << funct3[1:0] bytes; off = addr[2:0].
- mask16 = ((1<<size)-1) << off; be0 = mask16[7:0], be1 = mask16[15:8]; split = (be1 != 0).
- wd128 = {64'b0, wdata} << (8*off); wd0 = wd128[63:0], wd1 = wd128[127:64].
- addr0 = addr & ~7; addr1 = addr0 + 8, modulo 2^64.

Illegal funct3
- Illegal codes: load 3'b111; store with funct3[2]=1.
- Go to ERR, issue no bus traffic. Next cycle: resp_valid_o=1, resp_err_o=1, resp_rdata_o=0, then return to IDLE.

State machine
- IDLE -> REQ0 on accept.
- REQ0: mem_req_o=1 with addr0/be0/wd0/we. Hold all mem_* stable until mem_gnt_i. On grant -> WAIT0.
- WAIT0: mem_req_o=0. On mem_rvalid_i, capture rd0. Then go to REQ1 if split, else RESP.
- REQ1 / WAIT1: same as REQ0 / WAIT0, using addr1/be1/wd1; capture rd1. Then -> RESP.
- RESP: resp_valid_o=1 for exactly one cycle, resp_err_o=0 -> IDLE.
- mem_rvalid_i outside WAIT0/WAIT1 is ignored.

Load data
- r = ({rd1, rd0} >> 8*off)[63:0]; rd1 = 0 when not split.
- Signed loads sign-extend from bit 8*size-1; LBU/LHU/LWU zero-extend; LD passes through.
- Stores return 0.

Timing and flow
- Minimum latency, with gnt in the same cycle as req and rvalid one cycle later:
  - unsplit: resp_valid_o 3 cycles after the accept edge;
  - split: 5 cycles.
- Only one bus transaction is outstanding at any time.
- There is no response backpressure.

Reset mid-operation
- Abandon the transaction; no response is ever produced for it.
- A stale mem_rvalid_i arriving after reset is ignored.

Test Plan:
- SD, addr 0x10, wdata 0x1122334455667788, gnt immediate, rvalid +1 -> one transaction: addr 0x10, be 0xFF, wdata 0x1122334455667788; resp_valid 3 cycles after accept, rdata 0.
- LB, addr 0x23, memory returns 0x0000000080000000 for 0x20 -> mem_be 0x08; rdata 0xFFFFFFFFFFFFFF80. Same access as LBU -> 0x0000000000000080.
- LW, addr 0x1E, rdata at 0x18 = 0xBBAA000000000000, at 0x20 = 0x000000000000DDCC -> two transactions (0x18, be 0xC0; 0x20, be 0x03); rdata 0xFFFFFFFFDDCCBBAA; resp 5 cycles after accept.
- SH, addr 0x0F, wdata 0xBEEF, mem_gnt_i low for 3 cycles on the first transaction -> mem_* held stable while ungranted; first transaction 0x08, be 0x80, wdata[63:56]=0xEF; second 0x10, be 0x01, wdata[7:0]=0xBE.
- Load with funct3 3'b111 -> mem_req_o never asserts; one cycle after accept: resp_valid=1, resp_err=1, rdata 0.
- rst pulsed while in WAIT0, then a late mem_rvalid_i -> mem_req_o and resp_valid_o 0 during reset, no response generated, req_ready_o=1 after rst deasserts; next aligned LD completes normally.
